register_bank: RTL

Register bank directly downstream of the registers manager: accepts its address/write/read strobes, stores the DAQ configuration and status registers, answers write handshakes with `writeAck` and returns `readData`. Register contents are exported as flat outputs to the rest of the DAQ, including the channel-enable word consumed by the TDC enable logic and the sync error flag. The admin write path is distinct from the user (command) write path.

---
 rtl/registers_sv_pkg.sv | 33 +++
 rtl/sat_counter.sv | 24 ++
 rtl/register_bank.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/registers_sv_pkg.sv
// Shared register-map definitions for the DAQ register bank: addresses,
// reset values, fixed read constants and the write-handshake state type.
package registers_sv_pkg;

  // Register addresses as seen on the registers-manager address bus
  localparam logic [7:0] BankId_addr        = 8'h00;
  localparam logic [7:0] Control_addr       = 8'h01;
  localparam logic [7:0] ClkDivider_addr    = 8'h02;
  localparam logic [7:0] ChannelEnable_addr = 8'h08;
  localparam logic [7:0] FlagSyncError_addr = 8'h0A;
  localparam logic [7:0] ErrorCount_addr    = 8'h0B;

  // Fixed identification word and the value returned for holes in the map
  localparam logic [31:0] BankId_value       = 32'h5344_0001;
  localparam logic [31:0] UnmappedRead_value = 32'hDEAD_BEEF;

  // Reset values of the writable registers
  localparam logic [31:0] Control_reset       = 32'h0000_0000;
  localparam logic [15:0] ClkDivider_reset    = 16'd4;
  localparam logic [31:0] ChannelEnable_reset = 32'h0000_0000;
  localparam logic [31:0] FlagSyncError_reset = 32'h0000_0000;

  // Width of the saturating admin-write counter behind ErrorCount
  localparam int ErrorCount_width = 16;

  // Write handshake with the registers manager
  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_ACK     = 2'd1,
    WR_RELEASE = 2'd2
  } writeState_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, clear wins
// over inc. Asynchronous active-high reset.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  // Count up until every bit is set, then hold the value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/register_bank.sv
// DAQ configuration/status register bank behind the registers manager.
// Writes use a level/ack handshake (IDLE -> ACK -> RELEASE) so a held
// writeEnable commits only once; reads are a one-cycle registered strobe.
// Build option REGBANK_ADMIN_LOCK_EN: when defined, only admin writes may
// touch FlagSyncError and user writes there are acknowledged but ignored;
// when undefined, user writes clear the bits set in writeData.
module register_bank
  import registers_sv_pkg::*;
#(
  parameter int DATA_LENGTH = 32,
  parameter int ADDRWIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rsnt,
  input  logic [ADDRWIDTH-1:0]   address,
  input  logic [DATA_LENGTH-1:0] writeData,
  input  logic                   writeEnable,
  input  logic                   writeAdmin,
  input  logic                   readEnable,
  output logic                   writeAck,
  output logic [DATA_LENGTH-1:0] readData,
  output logic [DATA_LENGTH-1:0] ctrl,
  output logic [15:0]            clk_div,
  output logic [DATA_LENGTH-1:0] channel_enable,
  output logic                   sync_error_flag
);

`ifdef REGBANK_ADMIN_LOCK_EN
  localparam bit userClearEn = 1'b0;
`else
  localparam bit userClearEn = 1'b1;
`endif

  writeState_t                 state;
  writeState_t                 nextState;
  logic                        writeCommit;
  logic [DATA_LENGTH-1:0]      ctrlReg;
  logic [15:0]                 clkDivReg;
  logic [DATA_LENGTH-1:0]      channelEnableReg;
  logic [DATA_LENGTH-1:0]      flagSyncErrorReg;
  logic [ErrorCount_width-1:0] errorCount;
  logic                        errorCountInc;
  logic [DATA_LENGTH-1:0]      readMux;

  // Handshake state register; reset drops any write not yet committed
  always_ff @(posedge clk or posedge rsnt) begin
    if (rsnt) begin
      state <= WR_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Commit once in IDLE, acknowledge for one cycle, then wait for enable low
  always_comb begin
    nextState   = state;
    writeCommit = 1'b0;
    writeAck    = 1'b0;
    case (state)
      WR_IDLE: begin
        if (writeEnable) begin
          writeCommit = 1'b1;
          nextState   = WR_ACK;
        end
      end
      WR_ACK: begin
        writeAck  = 1'b1;
        nextState = WR_RELEASE;
      end
      WR_RELEASE: begin
        if (!writeEnable) begin
          nextState = WR_IDLE;
        end
      end
      default: begin
        nextState = WR_IDLE;
      end
    endcase
  end

  // Writable registers; RO and unmapped addresses fall through unchanged
  always_ff @(posedge clk or posedge rsnt) begin
    if (rsnt) begin
      ctrlReg          <= DATA_LENGTH'(Control_reset);
      clkDivReg        <= ClkDivider_reset;
      channelEnableReg <= DATA_LENGTH'(ChannelEnable_reset);
      flagSyncErrorReg <= DATA_LENGTH'(FlagSyncError_reset);
    end else if (writeCommit) begin
      case (address)
        ADDRWIDTH'(Control_addr): begin
          ctrlReg <= writeData;
        end
        ADDRWIDTH'(ClkDivider_addr): begin
          clkDivReg <= writeData[15:0];
        end
        ADDRWIDTH'(ChannelEnable_addr): begin
          channelEnableReg <= writeData;
        end
        ADDRWIDTH'(FlagSyncError_addr): begin
          if (writeAdmin) begin
            flagSyncErrorReg <= flagSyncErrorReg | writeData;
          end else if (userClearEn) begin
            flagSyncErrorReg <= flagSyncErrorReg & ~writeData;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Every admin write to the sync-error flag counts as one reported error
  assign errorCountInc = writeCommit && writeAdmin &&
                         (address == ADDRWIDTH'(FlagSyncError_addr));

  sat_counter #(
    .WIDTH (ErrorCount_width)
  ) errorCounter (
    .clk   (clk),
    .rst   (rsnt),
    .inc   (errorCountInc),
    .clear (1'b0),
    .count (errorCount)
  );

  // Read decode of the current (pre-write) register contents
  always_comb begin
    readMux = DATA_LENGTH'(UnmappedRead_value);
    case (address)
      ADDRWIDTH'(BankId_addr):        readMux = DATA_LENGTH'(BankId_value);
      ADDRWIDTH'(Control_addr):       readMux = ctrlReg;
      ADDRWIDTH'(ClkDivider_addr):    readMux = DATA_LENGTH'(clkDivReg);
      ADDRWIDTH'(ChannelEnable_addr): readMux = channelEnableReg;
      ADDRWIDTH'(FlagSyncError_addr): readMux = flagSyncErrorReg;
      ADDRWIDTH'(ErrorCount_addr):    readMux = DATA_LENGTH'(errorCount);
      default:                        readMux = DATA_LENGTH'(UnmappedRead_value);
    endcase
  end

  // Read result is captured on the strobe and held until the next strobe
  always_ff @(posedge clk or posedge rsnt) begin
    if (rsnt) begin
      readData <= '0;
    end else if (readEnable) begin
      readData <= readMux;
    end
  end

  assign ctrl            = ctrlReg;
  assign clk_div         = clkDivReg;
  assign channel_enable  = channelEnableReg;
  assign sync_error_flag = flagSyncErrorReg[0];

endmodule
